// File: rtl/timer_ctrl_master.sv
// Avalon-MM initiator for the 16-bit interval timer: turns start/stop/snapshot
// requests and the timer irq into register write/read sequences.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus idle, arbitrate irq > stop > start > snapshot
// WR_PL     | write period_l (addr 2)
// WR_PH     | write period_h (addr 3)
// GAP       | idle bus while the slave performs its force-reload stop
// WR_CTL    | write control (addr 1) with START and mode bits
// WR_STOP   | write control (addr 1) with STOP
// CLR_ST    | write status (addr 0) to clear timeout, pulse tick
// CLR_WAIT  | idle bus so irq can fall before the next sample
// SNAP_WR   | write snap_l (addr 4) to latch the counter
// SNAP_RL   | read address 4
// SNAP_RH   | read address 5, capture low half
// SNAP_DONE | capture high half, publish snapshot on exit
module timer_ctrl_master #(
    parameter bit CONTINUOUS = 1'b1,
    parameter bit IRQ_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [2:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [15:0] avm_writedata,
    input  logic [15:0] avm_readdata,
    input  logic        irq,
    input  logic [31:0] cfg_period,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic        cmd_snap,
    output logic        busy,
    output logic        running,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic [31:0] snapshot,
    output logic        snap_valid
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_GAP, S_WR_CTL, S_WR_STOP,
        S_CLR_ST, S_CLR_WAIT, S_SNAP_WR, S_SNAP_RL, S_SNAP_RH, S_SNAP_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_start_p, r_stop_p, r_snap_p;
    logic [15:0] r_period_h;
    logic [15:0] r_snap_lo;
    logic        r_running;
    logic [31:0] r_tick_count;
    logic [31:0] r_snapshot;
    logic        r_snap_valid;
    logic [2:0]  r_addr;
    logic        r_cs;
    logic        r_wn;
    logic [15:0] r_wdata;
    logic [2:0]  w_addr;
    logic        w_cs;
    logic        w_wn;
    logic [15:0] w_wdata;
    logic        w_go_start, w_go_stop, w_go_snap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (irq)            w_next = S_CLR_ST;
                else if (r_stop_p)  w_next = S_WR_STOP;
                else if (r_start_p) w_next = S_WR_PL;
                else if (r_snap_p)  w_next = S_SNAP_WR;
            end
            S_WR_PL:     w_next = S_WR_PH;
            S_WR_PH:     w_next = S_GAP;
            S_GAP:       w_next = S_WR_CTL;
            S_WR_CTL:    w_next = S_IDLE;
            S_WR_STOP:   w_next = S_IDLE;
            S_CLR_ST:    w_next = S_CLR_WAIT;
            S_CLR_WAIT:  w_next = S_IDLE;
            S_SNAP_WR:   w_next = S_SNAP_RL;
            S_SNAP_RL:   w_next = S_SNAP_RH;
            S_SNAP_RH:   w_next = S_SNAP_DONE;
            S_SNAP_DONE: w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Bus values are decoded from the next state so the registered outputs
    // line up with the cycle the FSM actually sits in that state.
    always_comb begin
        w_addr  = 3'd0;
        w_cs    = 1'b0;
        w_wn    = 1'b1;
        w_wdata = 16'h0000;
        case (w_next)
            S_WR_PL:   begin w_addr = 3'd2; w_cs = 1'b1; w_wn = 1'b0; w_wdata = cfg_period[15:0]; end
            S_WR_PH:   begin w_addr = 3'd3; w_cs = 1'b1; w_wn = 1'b0; w_wdata = r_period_h; end
            S_WR_CTL:  begin
                w_addr  = 3'd1; w_cs = 1'b1; w_wn = 1'b0;
                w_wdata = {12'h000, 1'b0, 1'b1, CONTINUOUS, IRQ_EN};
            end
            S_WR_STOP: begin w_addr = 3'd1; w_cs = 1'b1; w_wn = 1'b0; w_wdata = 16'h0008; end
            S_CLR_ST:  begin w_addr = 3'd0; w_cs = 1'b1; w_wn = 1'b0; end
            S_SNAP_WR: begin w_addr = 3'd4; w_cs = 1'b1; w_wn = 1'b0; end
            S_SNAP_RL: w_addr = 3'd4;
            S_SNAP_RH: w_addr = 3'd5;
            default:   ;
        endcase
    end

    assign w_go_stop  = (r_state == S_IDLE) && (w_next == S_WR_STOP);
    assign w_go_start = (r_state == S_IDLE) && (w_next == S_WR_PL);
    assign w_go_snap  = (r_state == S_IDLE) && (w_next == S_SNAP_WR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_p    <= 1'b0;
            r_stop_p     <= 1'b0;
            r_snap_p     <= 1'b0;
            r_period_h   <= 16'h0000;
            r_snap_lo    <= 16'h0000;
            r_running    <= 1'b0;
            r_tick_count <= 32'h0000_0000;
            r_snapshot   <= 32'h0000_0000;
            r_snap_valid <= 1'b0;
            r_addr       <= 3'd0;
            r_cs         <= 1'b0;
            r_wn         <= 1'b1;
            r_wdata      <= 16'h0000;
        end else begin
            r_start_p    <= w_go_start ? 1'b0 : (r_start_p | cmd_start);
            r_stop_p     <= w_go_stop  ? 1'b0 : (r_stop_p  | cmd_stop);
            r_snap_p     <= w_go_snap  ? 1'b0 : (r_snap_p  | cmd_snap);
            r_addr       <= w_addr;
            r_cs         <= w_cs;
            r_wn         <= w_wn;
            r_wdata      <= w_wdata;
            r_snap_valid <= 1'b0;
            if (w_go_start)             r_period_h   <= cfg_period[31:16];
            if (r_state == S_WR_CTL)    r_running    <= 1'b1;
            if (r_state == S_WR_STOP)   r_running    <= 1'b0;
            if (r_state == S_CLR_ST)    r_tick_count <= r_tick_count + 32'd1;
            if (r_state == S_SNAP_RH)   r_snap_lo    <= avm_readdata;
            if (r_state == S_SNAP_DONE) begin
                r_snapshot   <= {avm_readdata, r_snap_lo};
                r_snap_valid <= 1'b1;
            end
        end
    end

    assign avm_address    = r_addr;
    assign avm_chipselect = r_cs;
    assign avm_write_n    = r_wn;
    assign avm_writedata  = r_wdata;
    assign busy           = (r_state != S_IDLE);
    assign running        = r_running;
    assign tick           = (r_state == S_CLR_ST);
    assign tick_count     = r_tick_count;
    assign snapshot       = r_snapshot;
    assign snap_valid     = r_snap_valid;

endmodule
